// File: rtl/exception_unit.sv
// Machine-mode trap and CSR unit for the MEM stage: owns the M-mode CSR file,
// sequences each trap over two cycles and redirects the front end on traps and MRET.
module exception_unit #(
    parameter logic [31:0] TRAP_ADDR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic        interrupt,
    input  logic [2:0]  exp_vector_in,
    input  logic        mret_in,
    input  logic [31:0] inst_in,
    input  logic [31:0] epc_cur,
    input  logic [31:0] epc_next,
    input  logic        csr_rw_in,
    input  logic [1:0]  csr_wsc_mode_in,
    input  logic        csr_w_imm_mux,
    input  logic [11:0] csr_rw_addr_in,
    input  logic [31:0] csr_w_data_reg,
    input  logic [4:0]  csr_w_data_imm,
    output logic [31:0] csr_r_data_out,
    output logic [31:0] PC_redirect,
    output logic        redirect_mux,
    output logic        reg_FD_flush,
    output logic        reg_DE_flush,
    output logic        reg_EM_flush,
    output logic        reg_MW_flush,
    output logic        RegWrite_cancel
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [31:0] CAUSE_IRQ     = 32'h8000_000B;
    localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] CAUSE_ECALL   = 32'd11;

    // Bit positions within exp_vector_in = {EBREAK, illegal, ECALL}
    localparam int EXP_ECALL   = 0;
    localparam int EXP_ILLEGAL = 1;
    localparam int EXP_EBREAK  = 2;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        TRAP_WAIT = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic        mie_meie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [31:0] cause_lat_reg;
    logic [31:0] tval_lat_reg;

    logic        int_take;
    logic        exc_take;
    logic        trap_take;
    logic        mret_take;
    logic        csr_take;
    logic        csr_we;
    logic [31:0] trap_cause;
    logic [31:0] trap_tval;
    logic [31:0] trap_epc;
    logic [31:0] trap_base;
    logic [31:0] csr_src;
    logic [31:0] csr_new;
    logic        flush_all;

    // Event qualification; a trap outranks MRET and CSR writes in the same cycle.
    always_comb begin
        int_take  = interrupt & mstatus_mie_reg & mie_meie_reg;
        exc_take  = inst_valid & (|exp_vector_in);
        trap_take = (state_reg == IDLE) & (int_take | exc_take);
        mret_take = (state_reg == IDLE) & inst_valid & mret_in & ~trap_take;
        csr_take  = (state_reg == IDLE) & inst_valid & csr_rw_in & ~mret_in & ~trap_take;
        csr_we    = csr_take & (csr_wsc_mode_in != 2'b00);
    end

    always_comb begin
        trap_cause = CAUSE_ECALL;
        trap_tval  = 32'h0;
        trap_epc   = epc_cur;
        if (int_take) begin
            trap_cause = CAUSE_IRQ;
            trap_epc   = epc_next;
        end else if (exp_vector_in[EXP_ILLEGAL]) begin
            trap_cause = CAUSE_ILLEGAL;
            trap_tval  = inst_in;
        end else if (exp_vector_in[EXP_EBREAK]) begin
            trap_cause = CAUSE_EBREAK;
            trap_tval  = epc_cur;
        end
    end

    always_comb begin
        trap_base = {mtvec_reg[31:2], 2'b00};
        if (int_take && mtvec_reg[0]) begin
            trap_base = {mtvec_reg[31:2], 2'b00} + 32'd44;
        end
    end

    // Read path always reflects the current (pre-write) CSR contents.
    always_comb begin
        csr_r_data_out = 32'h0;
        case (csr_rw_addr_in)
            ADDR_MSTATUS:  csr_r_data_out = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg,
                                             3'b0, mstatus_mie_reg, 3'b0};
            ADDR_MIE:      csr_r_data_out = {20'b0, mie_meie_reg, 11'b0};
            ADDR_MTVEC:    csr_r_data_out = mtvec_reg;
            ADDR_MSCRATCH: csr_r_data_out = mscratch_reg;
            ADDR_MEPC:     csr_r_data_out = mepc_reg;
            ADDR_MCAUSE:   csr_r_data_out = mcause_reg;
            ADDR_MTVAL:    csr_r_data_out = mtval_reg;
            ADDR_MIP:      csr_r_data_out = {20'b0, interrupt, 11'b0};
            default:       csr_r_data_out = 32'h0;
        endcase
    end

    always_comb begin
        csr_src = csr_w_imm_mux ? {27'b0, csr_w_data_imm} : csr_w_data_reg;
        case (csr_wsc_mode_in)
            2'b01:   csr_new = csr_src;
            2'b10:   csr_new = csr_r_data_out | csr_src;
            2'b11:   csr_new = csr_r_data_out & ~csr_src;
            default: csr_new = csr_r_data_out;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (trap_take) state_next = TRAP_WAIT;
            TRAP_WAIT: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        redirect_mux    = 1'b0;
        PC_redirect     = 32'h0;
        flush_all       = 1'b0;
        RegWrite_cancel = 1'b0;
        if (!rst && state_reg == IDLE) begin
            if (trap_take) begin
                redirect_mux    = 1'b1;
                PC_redirect     = trap_base;
                flush_all       = 1'b1;
                RegWrite_cancel = ~int_take;
            end else if (mret_take) begin
                redirect_mux = 1'b1;
                PC_redirect  = mepc_reg;
                flush_all    = 1'b1;
            end
        end
    end

    assign reg_FD_flush = flush_all;
    assign reg_DE_flush = flush_all;
    assign reg_EM_flush = flush_all;
    assign reg_MW_flush = flush_all;

    // Cause and tval are captured at the trap edge and committed one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_lat_reg <= 32'h0;
            tval_lat_reg  <= 32'h0;
        end else if (trap_take) begin
            cause_lat_reg <= trap_cause;
            tval_lat_reg  <= trap_tval;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
        end else if (trap_take) begin
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (mret_take) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_we && csr_rw_addr_in == ADDR_MSTATUS) begin
            mstatus_mie_reg  <= csr_new[3];
            mstatus_mpie_reg <= csr_new[7];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_meie_reg <= 1'b0;
            mtvec_reg    <= TRAP_ADDR_RESET;
            mscratch_reg <= 32'h0;
        end else if (csr_we) begin
            if (csr_rw_addr_in == ADDR_MIE)      mie_meie_reg <= csr_new[11];
            if (csr_rw_addr_in == ADDR_MTVEC)    mtvec_reg    <= csr_new & 32'hFFFF_FFFD;
            if (csr_rw_addr_in == ADDR_MSCRATCH) mscratch_reg <= csr_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mepc_reg <= 32'h0;
        end else if (trap_take) begin
            mepc_reg <= trap_epc & 32'hFFFF_FFFC;
        end else if (csr_we && csr_rw_addr_in == ADDR_MEPC) begin
            mepc_reg <= csr_new & 32'hFFFF_FFFC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcause_reg <= 32'h0;
            mtval_reg  <= 32'h0;
        end else if (state_reg == TRAP_WAIT) begin
            mcause_reg <= cause_lat_reg;
            mtval_reg  <= tval_lat_reg;
        end else if (csr_we) begin
            if (csr_rw_addr_in == ADDR_MCAUSE) mcause_reg <= csr_new;
            if (csr_rw_addr_in == ADDR_MTVAL)  mtval_reg  <= csr_new;
        end
    end

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a word-level CSR/trap model.
module tb_exception_unit;

    localparam logic [31:0] TRAP_RST = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic        interrupt;
    logic [2:0]  exp_vector_in;
    logic        mret_in;
    logic [31:0] inst_in;
    logic [31:0] epc_cur;
    logic [31:0] epc_next;
    logic        csr_rw_in;
    logic [1:0]  csr_wsc_mode_in;
    logic        csr_w_imm_mux;
    logic [11:0] csr_rw_addr_in;
    logic [31:0] csr_w_data_reg;
    logic [4:0]  csr_w_data_imm;
    logic [31:0] csr_r_data_out;
    logic [31:0] PC_redirect;
    logic        redirect_mux;
    logic        reg_FD_flush;
    logic        reg_DE_flush;
    logic        reg_EM_flush;
    logic        reg_MW_flush;
    logic        RegWrite_cancel;

    int checks = 0;
    int errors = 0;

    exception_unit #(.TRAP_ADDR_RESET(TRAP_RST)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .interrupt(interrupt),
        .exp_vector_in(exp_vector_in), .mret_in(mret_in), .inst_in(inst_in),
        .epc_cur(epc_cur), .epc_next(epc_next), .csr_rw_in(csr_rw_in),
        .csr_wsc_mode_in(csr_wsc_mode_in), .csr_w_imm_mux(csr_w_imm_mux),
        .csr_rw_addr_in(csr_rw_addr_in), .csr_w_data_reg(csr_w_data_reg),
        .csr_w_data_imm(csr_w_data_imm), .csr_r_data_out(csr_r_data_out),
        .PC_redirect(PC_redirect), .redirect_mux(redirect_mux),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
        .RegWrite_cancel(RegWrite_cancel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (whole CSR words) ----------------
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    bit          m_wait;
    logic [31:0] m_pcause, m_ptval;

    task automatic m_reset();
        m_mstatus = 32'h1800; m_mie = 0; m_mtvec = TRAP_RST; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_wait = 0; m_pcause = 0; m_ptval = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return interrupt ? 32'h800 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: m_mstatus  = 32'h1800 | (v & 32'h88);
            12'h304: m_mie      = v & 32'h800;
            12'h305: m_mtvec    = v & ~32'h2;
            12'h340: m_mscratch = v;
            12'h341: m_mepc     = v & ~32'h3;
            12'h342: m_mcause   = v;
            12'h343: m_mtval    = v;
            default: ;
        endcase
    endtask

    task automatic m_step(input bit int_ok, input bit exc_ok);
        logic [31:0] src, oldv, newv;
        if (m_wait) begin
            m_mcause = m_pcause;
            m_mtval  = m_ptval;
            m_wait   = 0;
        end else if (int_ok || exc_ok) begin
            m_mepc    = (int_ok ? epc_next : epc_cur) & ~32'h3;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            if (int_ok) begin m_pcause = 32'h8000_000B; m_ptval = 0; end
            else if (exp_vector_in[1]) begin m_pcause = 2; m_ptval = inst_in; end
            else if (exp_vector_in[2]) begin m_pcause = 3; m_ptval = epc_cur; end
            else begin m_pcause = 11; m_ptval = 0; end
            m_wait = 1;
        end else if (inst_valid && mret_in) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (inst_valid && csr_rw_in && csr_wsc_mode_in != 2'b00) begin
            src  = csr_w_imm_mux ? {27'b0, csr_w_data_imm} : csr_w_data_reg;
            oldv = m_read(csr_rw_addr_in);
            case (csr_wsc_mode_in)
                2'b01:   newv = src;
                2'b10:   newv = oldv | src;
                default: newv = oldv & ~src;
            endcase
            m_write(csr_rw_addr_in, newv);
        end
    endtask

    // Compare process: every cycle, mid-period, then advance the model.
    always @(negedge clk) begin
        logic [31:0] e_pc, e_rd;
        logic        e_redir, e_fl, e_cancel;
        bit          int_ok, exc_ok;
        if (rst) m_reset();
        e_redir = 0; e_pc = 0; e_fl = 0; e_cancel = 0; int_ok = 0; exc_ok = 0;
        e_rd = m_read(csr_rw_addr_in);
        if (!rst && !m_wait) begin
            int_ok = interrupt && m_mstatus[3] && m_mie[11];
            exc_ok = inst_valid && (exp_vector_in != 3'b000);
            if (int_ok || exc_ok) begin
                e_redir  = 1;
                e_fl     = 1;
                e_cancel = !int_ok;
                e_pc     = (m_mtvec & ~32'h3) + ((int_ok && m_mtvec[0]) ? 32'd44 : 32'd0);
            end else if (inst_valid && mret_in) begin
                e_redir = 1;
                e_fl    = 1;
                e_pc    = m_mepc;
            end
        end
        chk("csr_r_data_out", csr_r_data_out, e_rd);
        chk("redirect_mux", redirect_mux, e_redir);
        chk("PC_redirect", PC_redirect, e_pc);
        chk("flushes", {reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush},
            e_fl ? 32'hF : 32'h0);
        chk("RegWrite_cancel", RegWrite_cancel, e_cancel);
        if (!rst) m_step(int_ok, exc_ok);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_valid = 0; interrupt = 0; exp_vector_in = 0; mret_in = 0;
        inst_in = 0; epc_cur = 0; epc_next = 0; csr_rw_in = 0;
        csr_wsc_mode_in = 0; csr_w_imm_mux = 0; csr_rw_addr_in = 0;
        csr_w_data_reg = 0; csr_w_data_imm = 0;
    endtask

    task automatic csr_op(input logic [1:0] mode, input logic imm_sel, input logic [11:0] a,
                          input logic [31:0] rv, input logic [4:0] iv, output logic [31:0] old);
        idle();
        inst_valid = 1; csr_rw_in = 1; csr_wsc_mode_in = mode; csr_w_imm_mux = imm_sel;
        csr_rw_addr_in = a; csr_w_data_reg = rv; csr_w_data_imm = iv;
        #2 old = csr_r_data_out;
        step();
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        idle();
        csr_rw_addr_in = a;
        #2 v = csr_r_data_out;
        step();
    endtask

    logic [11:0] addr_tab [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'h300, 12'h7C0};

    initial begin
        logic [31:0] v;
        rst = 1;
        idle();
        csr_rw_addr_in = 12'h300;
        #3 chk("lit_reset_mstatus", csr_r_data_out, 32'h1800);
        chk("lit_reset_redirect", redirect_mux, 0);
        step();
        step();
        rst = 0;
        rd(12'h305, v); chk("lit_reset_mtvec", v, TRAP_RST);

        // CSR operations
        csr_op(2'b01, 0, 12'h305, 32'h0000_0103, 0, v);
        rd(12'h305, v); chk("lit_csrrw_mtvec", v, 32'h0000_0101);
        csr_op(2'b10, 1, 12'h300, 0, 5'd8, v); chk("lit_csrrsi_old", v, 32'h1800);
        rd(12'h300, v); chk("lit_csrrsi_mie", v, 32'h1808);
        csr_op(2'b11, 0, 12'h300, 32'h8, 0, v);
        rd(12'h300, v); chk("lit_csrrc_mie", v, 32'h1800);

        // Illegal instruction
        csr_op(2'b01, 0, 12'h305, 32'h100, 0, v);
        idle(); inst_valid = 1; exp_vector_in = 3'b010; inst_in = 32'hFFFF_FFFF; epc_cur = 32'h40;
        #2 chk("lit_ill_redirect", redirect_mux, 1);
        chk("lit_ill_pc", PC_redirect, 32'h100);
        chk("lit_ill_cancel", RegWrite_cancel, 1);
        step();
        #1 chk("lit_wait_ignores_exc", redirect_mux, 0);
        chk("lit_wait_noflush", reg_FD_flush, 0);
        step();
        rd(12'h341, v); chk("lit_ill_mepc", v, 32'h40);
        rd(12'h342, v); chk("lit_ill_mcause", v, 32'd2);
        rd(12'h343, v); chk("lit_ill_mtval", v, 32'hFFFF_FFFF);

        // ECALL then MRET
        csr_op(2'b10, 1, 12'h300, 0, 5'd8, v);
        idle(); inst_valid = 1; exp_vector_in = 3'b001; epc_cur = 32'h80;
        step();
        idle();
        step();
        rd(12'h341, v); chk("lit_ecall_mepc", v, 32'h80);
        rd(12'h342, v); chk("lit_ecall_mcause", v, 32'd11);
        rd(12'h300, v); chk("lit_ecall_mstatus", v, 32'h1880);
        csr_op(2'b01, 0, 12'h341, 32'h84, 0, v);
        idle(); inst_valid = 1; mret_in = 1;
        #2 chk("lit_mret_pc", PC_redirect, 32'h84);
        chk("lit_mret_redirect", redirect_mux, 1);
        step();
        rd(12'h300, v); chk("lit_mret_mstatus", v, 32'h1888);

        // Interrupt beats ECALL and a CSR write; vectored mtvec
        csr_op(2'b01, 0, 12'h304, 32'h800, 0, v);
        csr_op(2'b01, 0, 12'h305, 32'h101, 0, v);
        idle(); interrupt = 1; inst_valid = 1; exp_vector_in = 3'b001;
        csr_rw_in = 1; csr_wsc_mode_in = 2'b01; csr_rw_addr_in = 12'h340;
        csr_w_data_reg = 32'hDEAD_BEEF; epc_cur = 32'h20; epc_next = 32'h24;
        #2 chk("lit_irq_pc", PC_redirect, 32'h12C);
        chk("lit_irq_cancel", RegWrite_cancel, 0);
        step();
        idle();
        step();
        rd(12'h342, v); chk("lit_irq_mcause", v, 32'h8000_000B);
        rd(12'h341, v); chk("lit_irq_mepc", v, 32'h24);
        rd(12'h340, v); chk("lit_irq_csr_suppressed", v, 32'h0);

        // Gating
        idle(); interrupt = 1; csr_rw_addr_in = 12'h344;
        #2 chk("lit_irq_masked", redirect_mux, 0);
        chk("lit_mip", csr_r_data_out, 32'h800);
        step();
        idle(); exp_vector_in = 3'b010;
        #2 chk("lit_invalid_no_trap", redirect_mux, 0);
        step();

        // Reset during TRAP_WAIT
        idle(); inst_valid = 1; exp_vector_in = 3'b001; epc_cur = 32'h90;
        step();
        idle(); rst = 1;
        #2 chk("lit_rst_wait_redirect", redirect_mux, 0);
        step();
        rst = 0;
        rd(12'h342, v); chk("lit_rst_wait_mcause", v, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                idle(); rst = 1; csr_rw_addr_in = 12'h300;
                #2 chk("lit_midrun_mstatus", csr_r_data_out, 32'h1800);
                chk("lit_midrun_flush", {reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush}, 0);
                step();
                rst = 0;
                rd(12'h305, v); chk("lit_midrun_mtvec", v, TRAP_RST);
            end
            inst_valid      = ($urandom_range(0, 9) < 7);
            interrupt       = ($urandom_range(0, 4) == 0);
            exp_vector_in   = ($urandom_range(0, 6) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            mret_in         = ($urandom_range(0, 11) == 0);
            csr_rw_in       = ($urandom_range(0, 2) == 0);
            csr_wsc_mode_in = 2'($urandom_range(0, 3));
            csr_w_imm_mux   = 1'($urandom_range(0, 1));
            csr_rw_addr_in  = addr_tab[$urandom_range(0, 9)];
            csr_w_data_reg  = $urandom;
            csr_w_data_imm  = 5'($urandom);
            inst_in         = $urandom;
            epc_cur         = $urandom;
            epc_next        = $urandom;
            step();
        end
        idle();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Machine-mode trap and CSR unit. Sits in the MEM stage, directly downstream of the decode control unit.
- Consumes the decoder's exception vector {EBREAK, illegal, ECALL}, MRET, csr_rw, csr_w_imm_mux and CSR operands as they arrive in MEM.
- Owns the M-mode CSR file and raises PC redirect and flush controls for traps and MRET.
- Each trap commits over a 2-cycle state machine; MRET and CSR accesses commit in one cycle.

Parameters:
TRAP_ADDR_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
inst_valid  input  1  MEM holds a real, non-bubble instruction
interrupt  input  1  external interrupt request, level
exp_vector_in  input  3  {EBREAK, illegal_inst, ECALL} from decode, piped to MEM
mret_in  input  1  MRET in MEM
inst_in  input  32  instruction word in MEM
epc_cur  input  32  PC of the instruction in MEM
epc_next  input  32  PC of the next instruction to complete (interrupt return point)
csr_rw_in  input  1  CSR instruction in MEM
csr_wsc_mode_in  input  2  funct3[1:0]: 01 write, 10 set, 11 clear
csr_w_imm_mux  input  1  1 = use zero-extended imm, 0 = use register
csr_rw_addr_in  input  12  CSR address
csr_w_data_reg  input  32  rs1 value
csr_w_data_imm  input  5  uimm field
csr_r_data_out  output  32  old CSR value, combinational
PC_redirect  output  32  redirect target
redirect_mux  output  1  1 = take PC_redirect
reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush  output  1 each  pipeline register flushes
RegWrite_cancel  output  1  suppress writeback of the trapping instruction

Behaviour:
CSR map:
- mstatus 0x300: MIE[3] and MPIE[7] writable; MPP[12:11] reads 11; other bits read 0.
- mie 0x304: only MEIE[11] writable.
- mtvec 0x305: MODE bit 1 forced 0.
- mscratch 0x340: full 32 bits.
- mepc 0x341: bits [1:0] forced 0.
- mcause 0x342: full 32 bits.
- mtval 0x343: full 32 bits.
- mip 0x344: read-only; MEIP[11] = interrupt.
- Unmapped addresses read 0; writes to them are ignored.

Reset (asynchronous, immediate):
- mstatus = 32'h0000_1800; mie, mscratch, mepc, mcause, mtval = 0; mtvec = TRAP_ADDR_RESET.
- FSM = IDLE.
- All outputs 0. csr_r_data_out follows its address.

Trap detection (IDLE only):
- int_take = interrupt & mstatus.MIE & mie.MEIE.
- exc = inst_valid & |exp_vector_in.
- A trap is taken when int_take | exc.
- Priority: interrupt > illegal (cause 2) > EBREAK (cause 3) > ECALL (cause 11). Interrupt cause = 32'h8000_000B.

Trap cycle T (IDLE -> TRAP_WAIT), combinational outputs:
- redirect_mux = 1.
- PC_redirect = {mtvec[31:2], 2'b00}. If mtvec[0] = 1 and the trap is an interrupt, PC_redirect = base + 4*11.
- All four flushes = 1.
- RegWrite_cancel = 1 for exceptions, 0 for interrupts.

Trap cycle T, registered at the edge:
- mepc <= epc_cur (exception) or epc_next (interrupt).
- MPIE <= MIE; MIE <= 0.
- The selected cause and tval are latched internally.

Cycle T+1 (TRAP_WAIT -> IDLE):
- mcause <= latched cause.
- mtval <= inst_in for illegal, epc_cur for EBREAK, 0 otherwise.
- All inputs are ignored; the instruction in MEM is already flushed.
- Outputs are 0.

MRET (IDLE, inst_valid & mret_in, no trap that cycle):
- redirect_mux = 1, PC_redirect = mepc.
- All flushes = 1.
- MIE <= MPIE; MPIE <= 1.
- FSM stays IDLE.

CSR access (IDLE, inst_valid & csr_rw_in, no trap):
- src = csr_w_imm_mux ? {27'b0, imm} : reg.
- New value: write = src; set = old | src; clear = old & ~src.
- Legalisation masks above are applied; the write lands at the next edge.
- csr_r_data_out always returns the pre-write value, with no bypass within the cycle.

Simultaneous events:
- A trap suppresses the CSR write and the MRET in the same cycle.
- inst_valid = 0 blocks exceptions, MRET and CSR writes; interrupts can still be taken.
- Reset during TRAP_WAIT returns to IDLE with mcause = 0.

Test Plan:
- Reset: rst pulse mid-run -> mstatus = 0x1800, mtvec = TRAP_ADDR_RESET, redirect_mux = 0, all flushes = 0.
- CSR ops:
  - CSRRW 0x305 with reg 0x0000_0103 -> mtvec reads 0x0000_0101.
  - CSRRSI 0x300 imm 8 -> MIE = 1, csr_r_data_out = 0x1800 in that cycle.
  - CSRRC 0x300 reg 0x8 -> MIE = 0.
- Illegal instruction: inst_in = 0xFFFF_FFFF at epc_cur = 0x40, mtvec = 0x100 -> cycle T: redirect to 0x100, 4 flushes, RegWrite_cancel = 1; T+1: mepc = 0x40, mcause = 2, mtval = 0xFFFF_FFFF; T+2: back in IDLE.
- ECALL then MRET: ECALL at 0x80 -> mepc = 0x80, mcause = 11. Handler writes mepc = 0x84, then MRET -> PC_redirect = 0x84, MIE restored from MPIE.
- Interrupt priority: MIE = 1, MEIE = 1, interrupt = 1 together with ECALL and a CSR write, epc_next = 0x24 -> mcause = 0x8000_000B, mepc = 0x24, CSR write suppressed, RegWrite_cancel = 0. With mtvec = 0x101 -> PC_redirect = 0x12C.
- Gating: interrupt with MIE = 0 -> no redirect. exp_vector_in = 3'b010 with inst_valid = 0 -> no trap. Exception arriving in TRAP_WAIT -> ignored.
